vgatest_seq: RTL and testbench

VGATEST_SEQ -- requirements
Module: vgatest_seq

---
 rtl/vgatest_seq.sv | 162 ++++++++++++++++
 tb/tb_vgatest_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/vgatest_seq.sv
// VGA test-pattern timing sequencer: IDLE -> PROLOGUE -> ACTIVE raster with shadowed mode.
// Optional frame counter on o_frames when VGATEST_SEQ_FRAMECOUNT_EN is defined.
module vgatest_seq #(
  parameter int HW = 12,
  parameter int VW = 12
) (
  input  logic          i_pixclk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic [HW-1:0] i_width,
  input  logic [HW-1:0] i_hsync_start,
  input  logic [HW-1:0] i_hsync_end,
  input  logic [HW-1:0] i_hraw,
  input  logic [VW-1:0] i_height,
  input  logic [VW-1:0] i_vsync_start,
  input  logic [VW-1:0] i_vsync_end,
  input  logic [VW-1:0] i_vraw,
  output logic          o_rd,
  output logic          o_newline,
  output logic          o_newframe,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_busy,
  output logic          o_err,
  output logic [15:0]   o_frames
);

  typedef enum logic [1:0] {IDLE, PROLOGUE, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hpos_q, hpos_d, w_q, w_d, hs_q, hs_d, he_q, he_d, hr_q, hr_d;
  logic [VW-1:0] vpos_q, vpos_d, ht_q, ht_d, vs_q, vs_d, ve_q, ve_d, vr_q, vr_d;
  logic          fin_q, fin_d, cont_q, cont_d, stop_err_q, stop_err_d;
  logic          rd_q, rd_d, nl_q, nl_d, nf_q, nf_d, hsy_q, hsy_d, vsy_q, vsy_d;
  logic          busy_q, busy_d, err_q, err_d;
  logic          mode_ok, capture, hwrap, act_n;

  assign mode_ok = (i_width != '0) && (i_width < i_hsync_start) &&
                   (i_hsync_start < i_hsync_end) && (i_hsync_end < i_hraw) &&
                   (i_height != '0) && (i_height < i_vsync_start) &&
                   (i_vsync_start < i_vsync_end) && (i_vsync_end < i_vraw);

  // Registers describe the cycle being presented; the comb block computes the next
  // cycle's position and its outputs. The end-of-frame go/stop decision is taken on
  // the edge entering the final cycle so that cycle's strobes can be suppressed.
  always_comb begin
    state_d    = state_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    fin_d      = 1'b0;
    cont_d     = 1'b0;
    stop_err_d = 1'b0;
    err_d      = err_q;
    capture    = 1'b0;
    hwrap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          if (mode_ok) begin
            state_d = PROLOGUE;
            capture = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PROLOGUE: begin
        state_d = ACTIVE;
        hpos_d  = '0;
        vpos_d  = '0;
      end
      ACTIVE: begin
        if (fin_q) begin
          hpos_d = '0;
          vpos_d = '0;
          if (!cont_q) begin
            state_d = IDLE;
            err_d   = stop_err_q;
          end
        end else begin
          hwrap  = (hpos_q == hr_q - HW'(1));
          hpos_d = hwrap ? '0 : hpos_q + HW'(1);
          if (hwrap) vpos_d = (vpos_q == vr_q - VW'(1)) ? '0 : vpos_q + VW'(1);
          if ((hpos_d == hr_q - HW'(1)) && (vpos_d == vr_q - VW'(1))) begin
            fin_d      = 1'b1;
            cont_d     = i_en && mode_ok;
            stop_err_d = i_en && !mode_ok;
            capture    = i_en && mode_ok;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    w_d  = capture ? i_width       : w_q;
    hs_d = capture ? i_hsync_start : hs_q;
    he_d = capture ? i_hsync_end   : he_q;
    hr_d = capture ? i_hraw        : hr_q;
    ht_d = capture ? i_height      : ht_q;
    vs_d = capture ? i_vsync_start : vs_q;
    ve_d = capture ? i_vsync_end   : ve_q;
    vr_d = capture ? i_vraw        : vr_q;

    // Next-cycle outputs always use the current shadows: a recapture only matters from (0,0) on.
    act_n  = (state_d == ACTIVE);
    rd_d   = act_n && (hpos_d < w_q) && (vpos_d < ht_q);
    nl_d   = (state_d == PROLOGUE) ||
             (act_n && (hpos_d == hr_q - HW'(1)) && (!fin_d || cont_d));
    nf_d   = (state_d == PROLOGUE) || (fin_d && cont_d);
    hsy_d  = act_n && (hpos_d >= hs_q) && (hpos_d < he_q);
    vsy_d  = act_n && (vpos_d >= vs_q) && (vpos_d < ve_q);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state_q <= IDLE;
      hpos_q <= '0; vpos_q <= '0;
      w_q <= '0; hs_q <= '0; he_q <= '0; hr_q <= '0;
      ht_q <= '0; vs_q <= '0; ve_q <= '0; vr_q <= '0;
      fin_q <= 1'b0; cont_q <= 1'b0; stop_err_q <= 1'b0;
      rd_q <= 1'b0; nl_q <= 1'b0; nf_q <= 1'b0; hsy_q <= 1'b0; vsy_q <= 1'b0;
      busy_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hpos_q <= hpos_d; vpos_q <= vpos_d;
      w_q <= w_d; hs_q <= hs_d; he_q <= he_d; hr_q <= hr_d;
      ht_q <= ht_d; vs_q <= vs_d; ve_q <= ve_d; vr_q <= vr_d;
      fin_q <= fin_d; cont_q <= cont_d; stop_err_q <= stop_err_d;
      rd_q <= rd_d; nl_q <= nl_d; nf_q <= nf_d; hsy_q <= hsy_d; vsy_q <= vsy_d;
      busy_q <= busy_d; err_q <= err_d;
    end
  end

  assign o_rd       = rd_q;
  assign o_newline  = nl_q;
  assign o_newframe = nf_q;
  assign o_hsync    = hsy_q;
  assign o_vsync    = vsy_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

`ifdef VGATEST_SEQ_FRAMECOUNT_EN
  logic [15:0] frames_q, frames_d;

  always_comb begin
    frames_d = frames_q;
    if (nf_d) frames_d = frames_q + 16'd1;
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) frames_q <= '0;
    else         frames_q <= frames_d;
  end

  assign o_frames = frames_q;
`else
  assign o_frames = '0;
`endif

endmodule

// File: tb/tb_vgatest_seq.sv
// Scoreboard bench for vgatest_seq: expected per-cycle outputs are queued as stimulus
// is applied and compared on each falling edge.
module tb_vgatest_seq;
  localparam int HW = 12;
  localparam int VW = 12;
`ifdef VGATEST_SEQ_FRAMECOUNT_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_reset, i_en;
  logic [HW-1:0] i_width, i_hsync_start, i_hsync_end, i_hraw;
  logic [VW-1:0] i_height, i_vsync_start, i_vsync_end, i_vraw;
  logic          o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_busy, o_err;
  logic [15:0]   o_frames;

  always #5 clk = ~clk;

  vgatest_seq #(.HW(HW), .VW(VW)) dut (
    .i_pixclk(clk), .i_reset(i_reset), .i_en(i_en),
    .i_width(i_width), .i_hsync_start(i_hsync_start), .i_hsync_end(i_hsync_end), .i_hraw(i_hraw),
    .i_height(i_height), .i_vsync_start(i_vsync_start), .i_vsync_end(i_vsync_end), .i_vraw(i_vraw),
    .o_rd(o_rd), .o_newline(o_newline), .o_newframe(o_newframe), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_busy(o_busy), .o_err(o_err), .o_frames(o_frames)
  );

  typedef struct packed {
    logic rd, nl, nf, hs, vs, busy, err;
    logic [15:0] fr;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   fcnt = 0;

  function automatic void push(input bit rd, nl, nf, hs, vs, busy, err);
    obs_t e;
    if (nf && FC) fcnt = (fcnt + 1) % 65536;
    e = {rd, nl, nf, hs, vs, busy, err, 16'(fcnt)};
    q.push_back(e);
  endfunction

  // Mode M raster: 8 x 6 cycles, hsync at h=5, vsync at v=4, active area w x 3.
  function automatic void push_frame(input int w, input bit end_strobe, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int  h, v;
      bit  last;
      h    = k % 8;
      v    = k / 8;
      last = (k == 47);
      push((h < w) && (v < 3), (h == 7) && (!last || end_strobe), last && end_strobe,
           (h >= 5) && (h < 6), (v >= 4) && (v < 5), 1'b1, 1'b0);
    end
  endfunction

  task automatic cyc(input string tag);
    obs_t o, e;
    @(negedge clk);
    o = {o_rd, o_newline, o_newframe, o_hsync, o_vsync, o_busy, o_err, o_frames};
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, o);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_en = 1'b0;
    i_width = 4; i_hsync_start = 5; i_hsync_end = 6; i_hraw = 8;
    i_height = 3; i_vsync_start = 4; i_vsync_end = 5; i_vraw = 6;

    repeat (2) push(0, 0, 0, 0, 0, 0, 0);
    cyc("reset"); cyc("reset");

    i_reset = 1'b0; i_en = 1'b1;
    push(0, 1, 1, 0, 0, 1, 0);
    cyc("prologue");
    for (int f = 0; f < 3; f++) begin
      push_frame(4, 1'b1, 48);
      for (int k = 0; k < 48; k++) cyc("frame");
    end

    push_frame(4, 1'b0, 48);
    for (int k = 0; k < 48; k++) begin
      cyc("stop_frame");
      if (k == 20) i_en = 1'b0;
    end
    repeat (3) push(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc("idle_after_stop");

    i_hsync_start = 3; i_en = 1'b1;
    repeat (3) push(0, 0, 0, 0, 0, 0, 1);
    repeat (3) cyc("bad_mode");
    i_hsync_start = 5;
    push(0, 1, 1, 0, 0, 1, 0);
    cyc("recover_prologue");

    push_frame(4, 1'b1, 48);
    for (int k = 0; k < 48; k++) begin
      cyc("midframe_change");
      if (k == 10) i_width = 2;
    end
    push_frame(2, 1'b0, 31);
    for (int k = 0; k < 31; k++) cyc("width2_frame");
    i_reset = 1'b1; i_en = 1'b0; fcnt = 0;
    push(0, 0, 0, 0, 0, 0, 0);
    cyc("reset_midframe");

    i_reset = 1'b0; i_width = 4; i_en = 1'b1;
    push(0, 1, 1, 0, 0, 1, 0);
    cyc("prologue2");
    i_reset = 1'b1; i_en = 1'b0; fcnt = 0;
    push(0, 0, 0, 0, 0, 0, 0);
    cyc("reset_prologue");

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: leftover=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
